// File: rtl/os_discard.sv
// Overlap-save discard stage: drops the aliased first half of each IFFT block, scales the kept half into a FIFO.
// Optional macro OS_DISCARD_SAT_EN selects saturating rather than wrapping width reduction.
module os_discard #(
   parameter int unsigned DWIDTH = 9,
   parameter int unsigned IWIDTH = 11,
   parameter int unsigned OS_N   = 16,
   parameter int unsigned SHIFT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifft_start,
   input  logic              ifft_valid,
   input  logic [IWIDTH-1:0] ifft_yI,
   input  logic [IWIDTH-1:0] ifft_yQ,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] out_I,
   output logic [DWIDTH-1:0] out_Q,
   output logic              blk_err,
   output logic [15:0]       blk_cnt
);

   localparam int unsigned CW    = $clog2(OS_N);
   localparam int unsigned DEPTH = 2 * OS_N;
   localparam int unsigned PW    = $clog2(DEPTH);
   localparam int unsigned FW    = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LAST = CW'(OS_N - 1);

   typedef enum logic [1:0] {IDLE, DISCARD, KEEP} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic              err_set, blk_inc;
   logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [FW-1:0]     fifo_cnt, fifo_cnt_nxt, after_rd;
   logic              do_wr, do_rd;
   logic [DWIDTH-1:0] sc_i, sc_q, head_i, head_q;
   logic [DWIDTH-1:0] mem_i [DEPTH];
   logic [DWIDTH-1:0] mem_q [DEPTH];

   // Arithmetic shift, then reduce to the output width.
   function automatic logic [DWIDTH-1:0] scale(input logic [IWIDTH-1:0] x);
      logic signed [IWIDTH-1:0] s;
      s = $signed(x) >>> SHIFT;
`ifdef OS_DISCARD_SAT_EN
      begin
         logic signed [IWIDTH-1:0] smax, smin;
         smax = IWIDTH'((2 ** (DWIDTH - 1)) - 1);
         smin = ~smax;
         if (s > smax)      s = smax;
         else if (s < smin) s = smin;
      end
`endif
      return DWIDTH'(s);
   endfunction

   assign sc_i = scale(ifft_yI);
   assign sc_q = scale(ifft_yQ);

   // Block framing: next state, sample counter, error and completion events.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      err_set   = 1'b0;
      blk_inc   = 1'b0;
      if (ifft_valid) begin
         if (ifft_start) begin
            state_nxt = DISCARD;
            cnt_nxt   = CW'(1);
            err_set   = (state != IDLE) || !in_ready;
         end else begin
            case (state)
               IDLE:    err_set = 1'b1;
               DISCARD: begin
                  if (cnt == LAST) begin
                     state_nxt = KEEP;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
               KEEP: begin
                  if (cnt == LAST) begin
                     state_nxt = IDLE;
                     cnt_nxt   = '0;
                     blk_inc   = 1'b1;
                  end else begin
                     cnt_nxt = cnt + CW'(1);
                  end
               end
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   // FIFO bookkeeping; a write into a full FIFO only lands if the head leaves this cycle.
   always_comb begin
      do_rd        = out_valid && out_ready;
      do_wr        = ifft_valid && !ifft_start && (state == KEEP) &&
                     ((fifo_cnt != FW'(DEPTH)) || do_rd);
      rd_ptr_nxt   = rd_ptr + PW'(do_rd);
      after_rd     = fifo_cnt - FW'(do_rd);
      fifo_cnt_nxt = after_rd + FW'(do_wr);
      head_i       = out_I;
      head_q       = out_Q;
      if (after_rd != '0) begin
         head_i = mem_i[rd_ptr_nxt];
         head_q = mem_q[rd_ptr_nxt];
      end else if (do_wr) begin
         head_i = sc_i;
         head_q = sc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_i[wr_ptr] <= sc_i;
         mem_q[wr_ptr] <= sc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifo_cnt  <= '0;
         out_valid <= 1'b0;
         out_I     <= '0;
         out_Q     <= '0;
         blk_err   <= 1'b0;
         blk_cnt   <= '0;
         in_ready  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         if (do_wr) wr_ptr <= wr_ptr + PW'(1);
         rd_ptr    <= rd_ptr_nxt;
         fifo_cnt  <= fifo_cnt_nxt;
         out_valid <= (fifo_cnt_nxt != '0);
         out_I     <= head_i;
         out_Q     <= head_q;
         blk_err   <= blk_err | err_set;
         if (blk_inc) blk_cnt <= blk_cnt + 16'd1;
         in_ready  <= (state_nxt == IDLE) && (fifo_cnt_nxt <= FW'(OS_N));
      end
   end

endmodule

// File: tb/tb_os_discard.sv
// Randomized bench for os_discard against a sample-position / queue reference model.
module tb_os_discard;

   localparam int unsigned DWIDTH = 9;
   localparam int unsigned IWIDTH = 11;
   localparam int unsigned OS_N   = 16;
   localparam int unsigned SHIFT  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ifft_start = 1'b0;
   logic              ifft_valid = 1'b0;
   logic [IWIDTH-1:0] ifft_yI = '0;
   logic [IWIDTH-1:0] ifft_yQ = '0;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DWIDTH-1:0] out_I;
   logic [DWIDTH-1:0] out_Q;
   logic              blk_err;
   logic [15:0]       blk_cnt;

   os_discard #(.DWIDTH(DWIDTH), .IWIDTH(IWIDTH), .OS_N(OS_N), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst), .ifft_start(ifft_start), .ifft_valid(ifft_valid),
      .ifft_yI(ifft_yI), .ifft_yQ(ifft_yQ), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_I(out_I), .out_Q(out_Q),
      .blk_err(blk_err), .blk_cnt(blk_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: position inside the current block (-1 = none), output queue, flags.
   int                    m_pos = -1;
   logic [2*DWIDTH-1:0]   m_q[$];
   logic                  m_err = 1'b0;
   int                    m_blks = 0;
   int                    rdy_mode = 1;   // 0: never ready, 1: always ready, 2: random
   logic                  ramp = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DWIDTH-1:0] ref_scale(input int x);
      int s;
      s = x >>> SHIFT;
`ifdef OS_DISCARD_SAT_EN
      if (s > (2 ** (DWIDTH - 1)) - 1) s = (2 ** (DWIDTH - 1)) - 1;
      if (s < -(2 ** (DWIDTH - 1)))    s = -(2 ** (DWIDTH - 1));
`endif
      return DWIDTH'(s);
   endfunction

   function automatic logic model_ready();
      return (m_pos < 0) && (m_q.size() <= OS_N);
   endfunction

   task automatic model_edge(input logic v, input logic s, input int yi, input int yq, input logic rd);
      logic rdy_now;
      rdy_now = model_ready();
      if (rd && m_q.size() > 0) void'(m_q.pop_front());
      if (v) begin
         if (s) begin
            if (m_pos >= 0 || !rdy_now) m_err = 1'b1;
            m_pos = 1;
         end else if (m_pos < 0) begin
            m_err = 1'b1;
         end else begin
            if (m_pos >= OS_N && m_q.size() < 2 * OS_N)
               m_q.push_back({ref_scale(yi), ref_scale(yq)});
            m_pos++;
            if (m_pos == 2 * OS_N) begin
               m_pos = -1;
               m_blks++;
            end
         end
      end
   endtask

   task automatic compare();
      logic [2*DWIDTH-1:0] h;
      check_val("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         h = m_q[0];
         check_val("out_I", 32'(out_I), 32'(h[2*DWIDTH-1:DWIDTH]));
         check_val("out_Q", 32'(out_Q), 32'(h[DWIDTH-1:0]));
      end
      check_val("in_ready", 32'(in_ready), 32'(model_ready()));
      check_val("blk_err", 32'(blk_err), 32'(m_err));
      check_val("blk_cnt", 32'(blk_cnt), 32'(m_blks & 16'hffff));
   endtask

   task automatic step(input logic v, input logic s, input int yi, input int yq);
      logic rd;
      rd = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      ifft_valid = v;
      ifft_start = s;
      ifft_yI    = IWIDTH'(yi);
      ifft_yQ    = IWIDTH'(yq);
      out_ready  = rd;
      model_edge(v, s, yi, yq, rd);
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 7) == 0), 0, 0);
   endtask

   // Sends n samples of a block (sample 0 carries start), with gap_pct percent idle cycles.
   task automatic send_block(input int n, input int gap_pct);
      int yi, yq;
      for (int k = 0; k < n; k++) begin
         while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'($urandom_range(0, 7) == 0), 0, 0);
         if (ramp) begin
            yi = 4 * k;
            yq = -4 * k;
         end else begin
            yi = $urandom_range(0, 2047) - 1024;
            yq = $urandom_range(0, 2047) - 1024;
         end
         step(1'b1, k == 0, yi, yq);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      ifft_valid = 1'b0;
      ifft_start = 1'b0;
      #1;
      check_val("rst_async_valid", 32'(out_valid), 32'd0);
      m_pos  = -1;
      m_q.delete();
      m_err  = 1'b0;
      m_blks = 0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out_I", 32'(out_I), 32'd0);
      check_val("rst_out_Q", 32'(out_Q), 32'd0);
      check_val("rst_blk_err", 32'(blk_err), 32'd0);
      check_val("rst_blk_cnt", 32'(blk_cnt), 32'd0);
      rst = 1'b0;
      idle(2);
   endtask

   initial begin
      do_reset();

      // Ramp block, continuous valid, always ready.
      ramp = 1'b1;
      rdy_mode = 1;
      send_block(2 * OS_N, 0);
      idle(4);
      check_val("ramp_blk_cnt", 32'(blk_cnt), 32'd1);
      check_val("ramp_blk_err", 32'(blk_err), 32'd0);

      // Three back-to-back blocks, stalled downstream during the first.
      do_reset();
      rdy_mode = 0;
      send_block(2 * OS_N, 0);
      rdy_mode = 1;
      send_block(2 * OS_N, 0);
      send_block(2 * OS_N, 0);
      idle(40);

      // Overflow: three blocks into a stalled output, then drain.
      do_reset();
      ramp = 1'b0;
      rdy_mode = 0;
      repeat (3) send_block(2 * OS_N, 0);
      rdy_mode = 1;
      idle(2 * OS_N + 4);

      // Restart at sample 20, then a full block.
      do_reset();
      ramp = 1'b1;
      send_block(20, 0);
      send_block(2 * OS_N, 0);
      idle(4);

      // Stray valid in IDLE, extreme sample values.
      do_reset();
      step(1'b1, 1'b0, 5, 5);
      step(1'b1, 1'b1, 0, 0);
      for (int k = 1; k < 2 * OS_N; k++)
         step(1'b1, 1'b0, (k % 3 == 0) ? 1023 : ((k % 3 == 1) ? -1024 : 1000), (k % 2) ? -1 : 1);
      idle(4);

      // Reset with five kept samples buffered, then a clean block.
      do_reset();
      rdy_mode = 0;
      send_block(OS_N + 5, 0);
      do_reset();
      rdy_mode = 1;
      ramp = 1'b0;
      send_block(2 * OS_N, 0);
      idle(4);

      // Random gaps, random downstream, occasional mid-block restarts.
      do_reset();
      rdy_mode = 2;
      for (int b = 0; b < 60; b++) begin
         if ($urandom_range(0, 9) == 0) send_block($urandom_range(1, 2 * OS_N - 1), 50);
         else send_block(2 * OS_N, 50);
         idle($urandom_range(0, 3));
      end
      rdy_mode = 1;
      idle(2 * OS_N + 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
